// File: rtl/gpio_pin_pkg.sv
// ============================================================================
// Module      : gpio_pin_pkg
// Description : Shared types and constants for the GPIO pin controller:
//               input-filter state encoding, drive-mode codes and the
//               debounce counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_pin_pkg;

  // Input filter states: settled on in_val, or qualifying a candidate change
  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } filt_state_e;

  // Values of od_mode
  localparam logic PUSH_PULL  = 1'b0;
  localparam logic OPEN_DRAIN = 1'b1;

  // Bits needed to count from 0 up to and including max_count
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_pin_sync.sv
// ============================================================================
// Module      : gpio_pin_sync
// Description : SYNC_STAGES-deep flop chain bringing the asynchronous pad
//               level into the HCLK domain. Flops reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the chain; bit 0 is the metastability catcher
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gpio_pin_ctrl.sv
// ============================================================================
// Module      : gpio_pin_ctrl
// Description : Single GPIO pin: registered push-pull / open-drain pad drive,
//               synchronized (optionally debounced) input, edge pulses and a
//               sticky edge interrupt.
//               Build option GPIO_PIN_DEBOUNCE_EN: when defined, a
//               DEBOUNCE_CYCLES qualification filter sits between the
//               synchronizer and in_val; when undefined, in_val is the last
//               synchronizer stage and DEBOUNCE_CYCLES has no effect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_pin_ctrl
  import gpio_pin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       out_val,
  input  logic       out_en,
  input  logic       od_mode,
  input  logic       pin_i,
  output logic       pin_o,
  output logic       pin_t,
  output logic       in_val,
  output logic       rise_evt,
  output logic       fall_evt,
  input  logic [1:0] irq_en,
  input  logic       irq_clr,
  output logic       irq
);

  // Reject illegal configurations at elaboration time
  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_debounce
    $error("gpio_pin_ctrl: DEBOUNCE_CYCLES must be 1..65535");
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
    $error("gpio_pin_ctrl: SYNC_STAGES must be 2..4");
  end

  logic sync_w;
  logic filt_w;
  logic pin_o_d, pin_o_q;
  logic pin_t_d, pin_t_q;
  logic in_prev_q;
  logic rise_q, fall_q, irq_q;
  logic irq_set_w;

  // --------------------------------------------------------------------------
  // Pad drive. Open-drain forces pin_o low and only ever releases the pad,
  // so a mode change lands on one edge with no pin_o=1/pin_t=0 overlap.
  // --------------------------------------------------------------------------
  // Select drive values for the current mode
  always_comb begin
    pin_o_d = out_val;
    pin_t_d = ~out_en;
    case (od_mode)
      PUSH_PULL: begin
        pin_o_d = out_val;
        pin_t_d = ~out_en;
      end
      OPEN_DRAIN: begin
        pin_o_d = 1'b0;
        pin_t_d = ~(out_en & ~out_val);
      end
    endcase
  end

  // Register the pad drive; reset releases the pad
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pin_o_q <= 1'b0;
      pin_t_q <= 1'b1;
    end else begin
      pin_o_q <= pin_o_d;
      pin_t_q <= pin_t_d;
    end
  end

  // --------------------------------------------------------------------------
  // Input path
  // --------------------------------------------------------------------------
  gpio_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .d_i    (pin_i),
    .q_o    (sync_w)
  );

`ifdef GPIO_PIN_DEBOUNCE_EN
  localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  filt_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // Qualify a candidate level for DEBOUNCE_CYCLES consecutive cycles; the
  // counter is loaded 1 on the first differing cycle and in_val flips on the
  // edge where it would reach DEBOUNCE_CYCLES, so it never wraps
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
    end else begin
      case (state_q)
        STABLE: begin
          if (sync_w != filt_q) begin
            if (CNT_MAX == CNT_ONE) begin
              filt_q <= sync_w;
            end else begin
              state_q <= QUALIFY;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        QUALIFY: begin
          if (sync_w == filt_q) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == (CNT_MAX - CNT_ONE)) begin
            filt_q  <= sync_w;
            state_q <= STABLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign filt_w = filt_q;
`else
  assign filt_w = sync_w;
`endif

  // --------------------------------------------------------------------------
  // Edge pulses and sticky interrupt
  // --------------------------------------------------------------------------
  assign irq_set_w = (rise_q & irq_en[0]) | (fall_q & irq_en[1]);

  // Pulse one cycle after in_val changes; irq set has priority over clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      in_prev_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      in_prev_q <= filt_w;
      rise_q    <= filt_w & ~in_prev_q;
      fall_q    <= ~filt_w & in_prev_q;
      irq_q     <= irq_set_w | (irq_q & ~irq_clr);
    end
  end

  assign pin_o    = pin_o_q;
  assign pin_t    = pin_t_q;
  assign in_val   = filt_w;
  assign rise_evt = rise_q;
  assign fall_evt = fall_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_pin_ctrl.sv
// ============================================================================
// Module      : tb_gpio_pin_ctrl
// Description : Self-checking bench for gpio_pin_ctrl (default parameters).
//               Expected input latency follows GPIO_PIN_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gpio_pin_ctrl;

  localparam int DEB  = 16;
  localparam int SYNC = 2;
`ifdef GPIO_PIN_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB;
`else
  localparam int LAT = SYNC;
`endif

  logic       HCLK    = 1'b0;
  logic       HRESETn = 1'b0;
  logic       out_val = 1'b0;
  logic       out_en  = 1'b0;
  logic       od_mode = 1'b0;
  logic       pin_i   = 1'b0;
  logic [1:0] irq_en  = 2'b00;
  logic       irq_clr = 1'b0;
  logic       pin_o, pin_t, in_val, rise_evt, fall_evt, irq;

  int n_checks = 0;
  int n_errors = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;

  typedef struct {
    logic out_val;
    logic out_en;
    logic od_mode;
    logic exp_o;
    logic exp_t;
  } drv_vec_t;

  gpio_pin_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .out_val  (out_val),
    .out_en   (out_en),
    .od_mode  (od_mode),
    .pin_i    (pin_i),
    .pin_o    (pin_o),
    .pin_t    (pin_t),
    .in_val   (in_val),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt),
    .irq_en   (irq_en),
    .irq_clr  (irq_clr),
    .irq      (irq)
  );

  always #5 HCLK = ~HCLK;

  // Advance one edge and sample 1 ns later; tally edge pulses seen
  task automatic tick();
    @(posedge HCLK);
    #1;
    rise_cnt += int'(rise_evt);
    fall_cnt += int'(fall_evt);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_cleared", irq, 1'b0);
  endtask

  // Drive pin_i to lvl and follow the change through in_val, pulse and irq
  task automatic run_edge(input logic lvl, input logic [1:0] en,
                          input logic clr_on_pulse, input logic exp_irq);
    rise_cnt = 0;
    fall_cnt = 0;
    irq_en   = en;
    pin_i    = lvl;
    for (int t = 1; t <= LAT + 3; t++) begin
      tick();
      if (t == LAT - 1) chk("in_val_before_latency", in_val, ~lvl);
      if (t == LAT) begin
        chk("in_val_at_latency", in_val, lvl);
        chk("no_pulse_yet", rise_evt | fall_evt, 1'b0);
      end
      if (t == LAT + 1) begin
        chk("edge_pulse", lvl ? rise_evt : fall_evt, 1'b1);
        chk("irq_not_yet", irq, 1'b0);
        if (clr_on_pulse) irq_clr = 1'b1;
      end
      if (t == LAT + 2) begin
        irq_clr = 1'b0;
        chk("pulse_one_cycle", rise_evt | fall_evt, 1'b0);
        chk("irq_after_edge", irq, exp_irq);
      end
      if (t == LAT + 3) chk("irq_hold", irq, exp_irq);
    end
    chk_int("rise_count", rise_cnt, lvl ? 1 : 0);
    chk_int("fall_count", fall_cnt, lvl ? 0 : 1);
  endtask

  drv_vec_t vecs [12];

  initial begin
    //            out_val out_en od_mode exp_o exp_t
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset with the output requested on
    HRESETn = 1'b0;
    out_en  = 1'b1;
    out_val = 1'b1;
    tick();
    tick();
    chk("rst_pin_t", pin_t, 1'b1);
    chk("rst_pin_o", pin_o, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_in_val", in_val, 1'b0);
    chk("rst_evts", rise_evt | fall_evt, 1'b0);
    HRESETn = 1'b1;
    #1;
    chk("release_pin_t", pin_t, 1'b1);
    chk("release_pin_o", pin_o, 1'b0);
    chk("release_irq", irq, 1'b0);
    tick();
    chk("first_edge_pin_t", pin_t, 1'b0);
    chk("first_edge_pin_o", pin_o, 1'b1);

    // Drive table, including mode switches with output enabled
    for (int i = 0; i < 12; i++) begin
      out_val = vecs[i].out_val;
      out_en  = vecs[i].out_en;
      od_mode = vecs[i].od_mode;
      tick();
      chk($sformatf("drv%0d_pin_o", i), pin_o, vecs[i].exp_o);
      chk($sformatf("drv%0d_pin_t", i), pin_t, vecs[i].exp_t);
    end

    // Edges and interrupt behaviour
    clear_irq();
    run_edge(1'b1, 2'b01, 1'b0, 1'b1);
    tick();
    chk("irq_sticky", irq, 1'b1);
    clear_irq();
    run_edge(1'b0, 2'b10, 1'b1, 1'b1);
    clear_irq();
    run_edge(1'b1, 2'b10, 1'b0, 1'b0);
    run_edge(1'b0, 2'b01, 1'b0, 1'b0);

`ifdef GPIO_PIN_DEBOUNCE_EN
    // Glitch one cycle shorter than the debounce window is rejected
    rise_cnt = 0;
    irq_en   = 2'b01;
    pin_i    = 1'b1;
    for (int t = 0; t < DEB - 1; t++) tick();
    pin_i = 1'b0;
    for (int t = 0; t < DEB + 4; t++) begin
      tick();
      if (t == 2) chk("glitch_in_val", in_val, 1'b0);
    end
    chk("glitch_in_val_end", in_val, 1'b0);
    chk_int("glitch_rise_count", rise_cnt, 0);
    chk("glitch_irq", irq, 1'b0);
`endif

    // Reset part way through a pending transition
    pin_i = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    HRESETn = 1'b0;
    #1;
    chk("midrst_in_val", in_val, 1'b0);
    chk("midrst_pin_t", pin_t, 1'b1);
    chk("midrst_irq", irq, 1'b0);
    pin_i = 1'b0;
    tick();
    HRESETn  = 1'b1;
    rise_cnt = 0;
    fall_cnt = 0;
    for (int t = 0; t < LAT + 4; t++) tick();
    chk_int("midrst_rise_count", rise_cnt, 0);
    chk_int("midrst_fall_count", fall_cnt, 0);
    chk("midrst_in_val_after", in_val, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
